// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array sequencer: state encoding and default geometry.
package systolic_pkg;

  localparam int DEFAULT_ARRAY_DIM  = 4;
  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_K_WIDTH    = 8;
  localparam int DRAIN_CYCLES       = 2 * DEFAULT_ARRAY_DIM;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Cycles for the last operand pair to cross an n x n grid.
  function automatic int drain_cycles(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// skew_line: zero-filled shift register of DEPTH stages; invalid input slots enter as zero.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg[0] <= '0;
    end else begin
      stage_reg[0] <= in_valid ? in_data : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_reg[gi] <= '0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign out_data = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN output-stationary MAC array: clear, feed K skewed operands, drain, done.
// Optional build macro SYSTOLIC_SEQ_CTRL_PERF_EN adds the perf_cycles busy-cycle counter.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM  = DEFAULT_ARRAY_DIM,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int K_WIDTH    = DEFAULT_K_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [K_WIDTH-1:0]              k_len,
  output logic                            busy,
  output logic                            done,
  output logic                            a_rd_en,
  output logic [K_WIDTH-1:0]              a_rd_addr,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] a_rd_data,
  output logic                            b_rd_en,
  output logic [K_WIDTH-1:0]              b_rd_addr,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] b_rd_data,
  output logic                            array_clear,
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  output logic [K_WIDTH+7:0]              perf_cycles,
`endif
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] left_edge,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] top_edge
);

  localparam int DRAIN_LEN = drain_cycles(ARRAY_DIM);
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  seq_state_t           state_reg;
  logic [K_WIDTH-1:0]   k_len_reg;
  logic [K_WIDTH-1:0]   rd_addr_reg;
  logic                 rd_en_reg;
  logic [DRAIN_W-1:0]   drain_cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 clear_reg;
  logic                 a_valid_reg;
  logic                 b_valid_reg;

  // All outputs are registered so the PE grid sees clean, glitch-free controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      k_len_reg     <= '0;
      rd_addr_reg   <= '0;
      rd_en_reg     <= 1'b0;
      drain_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      clear_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            k_len_reg <= k_len;
            busy_reg  <= 1'b1;
            clear_reg <= 1'b1;
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          clear_reg <= 1'b0;
          if (k_len_reg == '0) begin
            drain_cnt_reg <= DRAIN_W'(DRAIN_LEN - 1);
            state_reg     <= DRAIN;
          end else begin
            rd_en_reg   <= 1'b1;
            rd_addr_reg <= '0;
            state_reg   <= FEED;
          end
        end
        FEED: begin
          if (rd_addr_reg == k_len_reg - K_WIDTH'(1)) begin
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            drain_cnt_reg <= DRAIN_W'(DRAIN_LEN - 1);
            state_reg     <= DRAIN;
          end else begin
            rd_addr_reg <= rd_addr_reg + K_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          rd_en_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          clear_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Buffer read data arrives one cycle after the enable; this marks it valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
    end else begin
      a_valid_reg <= rd_en_reg;
      b_valid_reg <= rd_en_reg;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign array_clear = clear_reg;
  assign a_rd_en     = rd_en_reg;
  assign b_rd_en     = rd_en_reg;
  assign a_rd_addr   = rd_addr_reg;
  assign b_rd_addr   = rd_addr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_DIM; gi++) begin : g_skew
      skew_line #(
        .DEPTH      (gi + 1),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_left (
        .clk      (clk),
        .reset    (reset),
        .in_valid (a_valid_reg),
        .in_data  (a_rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .out_data (left_edge[gi*DATA_WIDTH +: DATA_WIDTH])
      );

      skew_line #(
        .DEPTH      (gi + 1),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_top (
        .clk      (clk),
        .reset    (reset),
        .in_valid (b_valid_reg),
        .in_data  (b_rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .out_data (top_edge[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [K_WIDTH+7:0] perf_reg;

  // Counts busy cycles of the latest pass; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      perf_reg <= '0;
    end else if (busy_reg && perf_reg != '1) begin
      perf_reg <= perf_reg + 1'b1;
    end
  end

  assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a registered-read buffer model and a 4x4 PE grid model.
module tb_systolic_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, a_rd_en, b_rd_en, array_clear;
  logic [KW-1:0]   a_rd_addr, b_rd_addr;
  logic [N*DW-1:0] a_rd_data = '0;
  logic [N*DW-1:0] b_rd_data = '0;
  logic [N*DW-1:0] left_edge, top_edge;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [KW+7:0]   perf_cycles;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] a_mem [16][N];
  logic [DW-1:0] b_mem [16][N];
  logic [7:0]    pe_sum   [N][N];
  logic [DW-1:0] pe_right [N][N];
  logic [DW-1:0] pe_down  [N][N];
  logic [7:0]    exp_sum  [N][N];
  int            left3_first, left3_last;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(
    .ARRAY_DIM  (N),
    .DATA_WIDTH (DW),
    .K_WIDTH    (KW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_en     (b_rd_en),
    .b_rd_addr   (b_rd_addr),
    .b_rd_data   (b_rd_data),
    .array_clear (array_clear),
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .left_edge   (left_edge),
    .top_edge    (top_edge)
  );

  // Operand buffers: registered read, data holds when not enabled.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (a_rd_en) a_rd_data[i*DW +: DW] <= a_mem[a_rd_addr[3:0]][i];
      if (b_rd_en) b_rd_data[i*DW +: DW] <= b_mem[b_rd_addr[3:0]][i];
    end
  end

  function automatic logic [DW-1:0] pe_in_left(input int i, input int j);
    if (j == 0) return left_edge[i*DW +: DW];
    return pe_right[i][j-1];
  endfunction

  function automatic logic [DW-1:0] pe_in_top(input int i, input int j);
    if (i == 0) return top_edge[j*DW +: DW];
    return pe_down[i-1][j];
  endfunction

  // PE grid: accumulate left*top every clock, forward operands right/down.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset || array_clear) begin
          pe_sum[i][j]   <= '0;
          pe_right[i][j] <= '0;
          pe_down[i][j]  <= '0;
        end else begin
          pe_sum[i][j]   <= pe_sum[i][j] + 8'(pe_in_left(i, j)) * 8'(pe_in_top(i, j));
          pe_right[i][j] <= pe_in_left(i, j);
          pe_down[i][j]  <= pe_in_top(i, j);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_en"}, 32'({a_rd_en, b_rd_en}), 0);
    check({tag, "_clear"}, 32'(array_clear), 0);
    check({tag, "_addr"}, 32'({a_rd_addr, b_rd_addr}), 0);
    check({tag, "_left"}, 32'(left_edge), 0);
    check({tag, "_top"}, 32'(top_edge), 0);
  endtask

  // One pass: start accepted in cycle 0, observed through cycle 24.
  task automatic run_pass(input logic [KW-1:0] k, input int exp_done,
                          input int extra_a, input int extra_b, input string tag);
    int done_cnt = 0, done_cyc = -1, rd_cnt = 0, clear_cnt = 0, clear_cyc = -1;
    logic busy1 = 1'b0, busy_done = 1'b0, busy_after = 1'b1;
    left3_first = -1;
    left3_last  = -1;
    k_len = k;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (done) begin done_cnt++; done_cyc = n; end
      if (a_rd_en) rd_cnt++;
      if (array_clear) begin clear_cnt++; clear_cyc = n; end
      if (n == 1) busy1 = busy;
      if (n == exp_done) busy_done = busy;
      if (n == exp_done + 1) busy_after = busy;
      if (left_edge[3*DW +: DW] != '0) begin
        if (left3_first < 0) left3_first = n - 2;
        left3_last = n - 2;
      end
      start = (n == extra_a || n == extra_b);
      step();
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_done_count"}, 32'(done_cnt), 1);
    check({tag, "_rd_count"}, 32'(rd_cnt), 32'(k));
    check({tag, "_clear_count"}, 32'(clear_cnt), 1);
    check({tag, "_clear_cycle"}, 32'(clear_cyc), 1);
    check({tag, "_busy_c1"}, 32'(busy1), 1);
    check({tag, "_busy_done"}, 32'(busy_done), 1);
    check({tag, "_busy_after"}, 32'(busy_after), 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_sum%0d%0d", tag, i, j), 32'(pe_sum[i][j]), 32'(exp_sum[i][j]));
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check({tag, "_perf"}, 32'(perf_cycles), 32'(exp_done));
`endif
    $display("pass %s: k=%0d done_cycle=%0d done_count=%0d reads=%0d", tag, k, done_cyc, done_cnt, rd_cnt);
  endtask

  task automatic load_identity();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < N; i++) begin
        a_mem[k][i] = (k == i) ? 4'd1 : 4'd0;
        b_mem[k][i] = (k < N) ? DW'(k + i) : 4'd0;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_sum[i][j] = 8'(i + j);
  endtask

  initial begin
    load_identity();

    repeat (3) step();
    check_idle("in_reset");
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    check("reset_perf", 32'(perf_cycles), 0);
`endif
    reset = 1'b0;
    step();
    check_idle("after_reset");

    run_pass(8'd4, 14, 0, 0, "ident1");

    for (int k = 0; k < 16; k++)
      for (int i = 0; i < N; i++) begin
        a_mem[k][i] = 4'd15;
        b_mem[k][i] = 4'd15;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_sum[i][j] = 8'd132;
    run_pass(8'd4, 14, 5, 14, "all15");
    check("all15_left3_first", 32'(left3_first), 5);
    check("all15_left3_last", 32'(left3_last), 8);

    load_identity();
    run_pass(8'd4, 14, 0, 0, "ident2");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_sum[i][j] = 8'd0;
    run_pass(8'd0, 10, 0, 0, "k0");

    // Abort in FEED cycle c=2, then a fresh pass.
    load_identity();
    k_len = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("midrst_feed_en", 32'(a_rd_en), 1);
    check("midrst_feed_addr", 32'(a_rd_addr), 2);
    reset = 1'b1;
    step();
    check_idle("midrst");
    reset = 1'b0;
    step();
    run_pass(8'd4, 14, 0, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the NxN output-stationary array of multiply-accumulate PEs: clears accumulators, streams K operand columns/rows from two operand buffers, applies diagonal skew on the left/top edges, waits for drain, pulses done.
- Sits between the operand buffers (registered read, 1-cycle latency) and the PE grid's left/top edge inputs and reset.
- PE contract relied on: accumulates in_left*in_top every clock; forwards operands right/down with 1-cycle latency.

Parameters:
- ARRAY_DIM, 4, N: rows = columns of PE grid
- DATA_WIDTH, 4, operand element width (matches PE)
- K_WIDTH, 8, width of inner-dimension length and buffer address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request one matrix-multiply pass; accepted only in IDLE
- k_len  in  K_WIDTH  inner dimension K; latched on start accept
- busy  out  1  high from accept cycle+1 through DONE cycle
- done  out  1  one-cycle pulse; PE sums valid and stable
- a_rd_en  out  1  A buffer read enable
- a_rd_addr  out  K_WIDTH  A column index k
- a_rd_data  in  N*DATA_WIDTH  element i = A[i][k], valid the cycle after a_rd_en
- b_rd_en  out  1  B buffer read enable
- b_rd_addr  out  K_WIDTH  B row index k
- b_rd_data  in  N*DATA_WIDTH  element j = B[k][j], valid the cycle after b_rd_en
- array_clear  out  1  drives PE grid reset; clears all sums
- left_edge  out  N*DATA_WIDTH  element i -> in_left of PE(i,0)
- top_edge  out  N*DATA_WIDTH  element j -> in_top of PE(0,j)

Behaviour:
- Reset: state IDLE; busy, done, a_rd_en, b_rd_en, array_clear = 0; addresses = 0; all skew registers and edges = 0. Reset mid-operation aborts immediately, same values; PE sums not cleared by this block.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches k_len, goes to CLEAR. start in any other state ignored (no queueing).
- CLEAR: 1 cycle, array_clear=1 (registered output, glitch-free).
- FEED: K cycles, c = 0..K-1: a_rd_en = b_rd_en = 1, both addresses = c. If K=0, skip FEED (CLEAR -> DRAIN).
- Valid pipeline: rd_en delayed 1 cycle marks buffer data valid. Edge row i = valid-gated a_rd_data[i] through i+1 registers; column j likewise with b_rd_data[j]. Invalid slots inject 0, so idle cycles add 0 to sums.
- Timing relative to FEED start: A[i][c] on left_edge[i] in cycle c+2+i; last product at PE(N-1,N-1) accumulates at end of cycle K+2N-1.
- DRAIN: exactly 2N cycles, down-counter; edges keep shifting zeros.
- DONE: done=1 for 1 cycle, busy still 1; then IDLE. start in the DONE cycle ignored.
- Latency: start accepted in cycle 0 -> done in cycle K+2N+2.
- Address counter is K_WIDTH bits; max K = 2^K_WIDTH-1, so no wrap within a pass.

Optional Feature:
- SYSTOLIC_SEQ_CTRL_PERF_EN defined: adds output perf_cycles (K_WIDTH+8 bits), reset 0; cleared on start accept, +1 each busy cycle, saturates, holds after done. Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package systolic_pkg: state encoding constants (IDLE, CLEAR, FEED, DRAIN, DONE), default ARRAY_DIM/DATA_WIDTH, DRAIN_CYCLES = 2*ARRAY_DIM.
- Sub-module skew_line (params DEPTH, DATA_WIDTH; valid-gated, zero-filled shift register, synchronous reset), generated 2N times with DEPTH = index+1.

Test Plan:
- N=4, K=4, A = identity, B[k][j] = k+j, PE grid + 1-cycle buffer model -> done exactly cycle 14 after accept; PE(i,j).sum = i+j; no other done pulses.
- N=4, K=4, all A = B = 15 -> every sum = 900 (8-bit wrap to 132 with DATA_WIDTH=4 PE); left_edge[3] nonzero only in FEED-relative cycles 5..8.
- Back-to-back: second start during busy and in DONE cycle -> ignored; start after return to IDLE -> array_clear pulse, sums reflect only second pass.
- K=0 -> CLEAR, no rd_en, done at cycle 10, all sums 0.
- reset asserted in FEED cycle 2 -> next cycle IDLE, busy=0, rd_en=0, edges 0; fresh start completes normally.
- PERF_EN build, K=4, N=4 -> perf_cycles = 14 after done; held until next accept.
